// File: rtl/clock_gen_if.sv
// Control/status bundle for clock_gen: enable request in, generated clock and strobes out.
// master = the controlling side, slave = the clock generator itself.
interface clock_gen_if;
    logic enable;
    logic clk_out;
    logic rise_pulse;
    logic running;

    modport master (output enable, input clk_out, input rise_pulse, input running);
    modport slave  (input enable, output clk_out, output rise_pulse, output running);
endinterface

// File: rtl/clock_gen.sv
// Gateable divided-clock generator: period DIV reference cycles, HIGH of them high, glitch-free.
// Optional start-phase delay from IDLE is enabled by defining CLKGEN_PHASE_EN (adds parameter PHASE).
module clock_gen #(
    parameter int REF_KHZ = 400000,
    parameter int FREQ    = 100000,
    parameter int DUTY    = 50
`ifdef CLKGEN_PHASE_EN
    ,
    parameter int PHASE   = 0
`endif
) (
    input  logic        clk,
    input  logic        rst_n,
    clock_gen_if.slave  bus
);

    localparam int DIV      = REF_KHZ / FREQ;
    localparam int HIGH_RAW = (DIV * DUTY + 50) / 100;
    localparam int HIGH     = (HIGH_RAW < 1) ? 1 : ((HIGH_RAW > DIV - 1) ? DIV - 1 : HIGH_RAW);
    localparam int CW       = (DIV < 2) ? 1 : $clog2(DIV);

    localparam logic [CW-1:0] LAST   = CW'(DIV - 1);
    localparam logic [CW-1:0] HIGH_C = CW'(HIGH);

    if (DIV < 2) begin : g_bad_div
        $fatal(1, "clock_gen: REF_KHZ/FREQ must be at least 2");
    end
    if (DUTY < 1 || DUTY > 99) begin : g_bad_duty
        $fatal(1, "clock_gen: DUTY must lie in 1..99");
    end

`ifdef CLKGEN_PHASE_EN
    if (PHASE < 0 || PHASE > DIV - 1) begin : g_bad_phase
        $fatal(1, "clock_gen: PHASE must lie in 0..DIV-1");
    end
    localparam logic [CW-1:0] PH_LAST = CW'((PHASE > 0) ? PHASE - 1 : 0);
`endif

    typedef enum logic [1:0] {IDLE, RUN, DELAY} state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic          clk_out_q;
    logic          rise_q;
    logic          running_q;
    logic [CW-1:0] cnt_inc;

    assign cnt_inc = cnt_q + CW'(1);

    // Enable is only consulted at period boundaries, so a running period always completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            clk_out_q <= 1'b0;
            rise_q    <= 1'b0;
            running_q <= 1'b0;
        end else begin
            rise_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    cnt_q     <= '0;
                    clk_out_q <= 1'b0;
                    running_q <= 1'b0;
                    if (bus.enable) begin
                        running_q <= 1'b1;
`ifdef CLKGEN_PHASE_EN
                        if (PHASE != 0) begin
                            state_q <= DELAY;
                        end else begin
                            state_q   <= RUN;
                            clk_out_q <= 1'b1;
                            rise_q    <= 1'b1;
                        end
`else
                        state_q   <= RUN;
                        clk_out_q <= 1'b1;
                        rise_q    <= 1'b1;
`endif
                    end
                end
                RUN: begin
                    if (cnt_q == LAST) begin
                        cnt_q <= '0;
                        if (bus.enable) begin
                            clk_out_q <= 1'b1;
                            rise_q    <= 1'b1;
                        end else begin
                            state_q   <= IDLE;
                            clk_out_q <= 1'b0;
                            running_q <= 1'b0;
                        end
                    end else begin
                        cnt_q     <= cnt_inc;
                        clk_out_q <= (cnt_inc < HIGH_C);
                    end
                end
`ifdef CLKGEN_PHASE_EN
                DELAY: begin
                    if (!bus.enable) begin
                        state_q   <= IDLE;
                        cnt_q     <= '0;
                        running_q <= 1'b0;
                    end else if (cnt_q == PH_LAST) begin
                        state_q   <= RUN;
                        cnt_q     <= '0;
                        clk_out_q <= 1'b1;
                        rise_q    <= 1'b1;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
`endif
                default: begin
                    state_q   <= IDLE;
                    cnt_q     <= '0;
                    clk_out_q <= 1'b0;
                    running_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.clk_out    = clk_out_q;
    assign bus.rise_pulse = rise_q;
    assign bus.running    = running_q;

endmodule

// File: tb/tb_clock_gen.sv
// Scoreboard bench for clock_gen: four instances (DIV=4/50%, DIV=8 at 25/75/60%) share clk and rst_n.
// Stimulus pushes the expected {clk_out, rise_pulse, running} per cycle; a negedge monitor pops and compares.
module tb_clock_gen;

    logic       clk;
    logic       rst_n;
    logic [3:0] en_tb;
    logic [2:0] obs [4];

    typedef struct {
        int         dut;
        logic [2:0] exp;
        int         cyc;
        string      tag;
    } sb_t;

    sb_t sb[$];
    sb_t mon_e;
    int  n_cmp = 0;
    int  n_bad = 0;

    genvar gi;
    for (gi = 0; gi < 4; gi++) begin : g_dut
        clock_gen_if bus ();
        assign bus.enable = en_tb[gi];
        assign obs[gi]    = {bus.clk_out, bus.rise_pulse, bus.running};
        clock_gen #(
            .REF_KHZ (400000),
            .FREQ    ((gi == 0) ? 100000 : 50000),
            .DUTY    ((gi == 0) ? 50 : (gi == 1) ? 25 : (gi == 2) ? 75 : 60)
        ) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus)
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit bit_at(input string s, input int i);
        return (s.getc(i) == "1");
    endfunction

    function automatic string rep(input string c, input int n);
        string s = "";
        for (int i = 0; i < n; i++) s = {s, c};
        return s;
    endfunction

    // Monitor: entries pushed during the previous cycle describe the outputs visible now.
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            mon_e = sb.pop_front();
            n_cmp++;
            if (obs[mon_e.dut] !== mon_e.exp) begin
                n_bad++;
                $display("FAIL %s dut%0d step%0d: got clk_out/rise/running=%b required %b",
                         mon_e.tag, mon_e.dut, mon_e.cyc, obs[mon_e.dut], mon_e.exp);
            end
        end
    end

    task automatic check(input string name, input int d, input logic [2:0] got, input logic [2:0] req);
        n_cmp++;
        if (got !== req) begin
            n_bad++;
            $display("FAIL %s dut%0d: got clk_out/rise/running=%b required %b", name, d, got, req);
        end
    endtask

    // One step per character; dut < 0 means every instance idles with enable low.
    task automatic run_seg(input int dut, input string tag, input string en,
                           input string co, input string rp, input string rn);
        for (int i = 0; i < en.len(); i++) begin
            @(negedge clk);
            #1;
            for (int d = 0; d < 4; d++) begin
                sb_t e;
                en_tb[d] = (d == dut) ? bit_at(en, i) : 1'b0;
                e.dut = d;
                e.cyc = i;
                e.tag = tag;
                e.exp = (d == dut) ? {bit_at(co, i), bit_at(rp, i), bit_at(rn, i)} : 3'b000;
                sb.push_back(e);
            end
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        en_tb = 4'b0000;
        @(negedge clk);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        en_tb = 4'b0000;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 4; d++) check("reset", d, obs[d], 3'b000);
        #1;
        rst_n = 1'b1;

        run_seg(-1, "idle50", rep("0", 50), rep("0", 50), rep("0", 50), rep("0", 50));

        apply_reset();
        run_seg(0, "div4_d50", rep("1", 12), rep("1100", 3), rep("1000", 3), rep("1", 12));

        apply_reset();
        run_seg(1, "div8_d25", rep("1", 16), rep("11000000", 2), rep("10000000", 2), rep("1", 16));

        apply_reset();
        run_seg(2, "div8_d75", rep("1", 16), rep("11111100", 2), rep("10000000", 2), rep("1", 16));

        apply_reset();
        run_seg(3, "div8_d60", rep("1", 16), rep("11111000", 2), rep("10000000", 2), rep("1", 16));

        apply_reset();
        run_seg(1, "drain", {"11", rep("0", 10)}, {"11", rep("0", 10)},
                {"1", rep("0", 11)}, {rep("1", 8), rep("0", 4)});

        apply_reset();
        run_seg(1, "seamless", {"111", "00", rep("1", 13)}, {rep("11000000", 2), "11"},
                {rep("10000000", 2), "10"}, rep("1", 18));

        apply_reset();
        run_seg(0, "pre_rst", "11111", "11001", "10001", "11111");
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < 4; d++) check("async_rst", d, obs[d], 3'b000);
        en_tb = 4'b0000;
        @(negedge clk);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        run_seg(0, "restart", "11111", "11001", "10001", "11111");

        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL sb_drain: got %0d pending entries required 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/clock_gen.md
Name: clock_gen

Overview:
- Synthesizable divided-clock generator.
- Derives a gateable output clock of programmable frequency and duty cycle from one fast reference clock.
- Used as a clock/strobe source for slower peripheral logic and test structures.
- Output is registered (glitch-free); start/stop is controlled by a level enable.

Parameters:
- REF_KHZ, 400000, reference clock frequency in kHz.
- FREQ, 100000, target output frequency in kHz.
- DUTY, 50, high-time percentage, legal range 1..99.
- Derived, not overridable: DIV = REF_KHZ/FREQ (integer truncation).
- Derived, not overridable: HIGH = (DIV*DUTY+50)/100, clamped to [1, DIV-1].

Ports:
- clk  input  1  reference clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- enable  input  1  level request to run the output clock.
- clk_out  output  1  generated clock (registered).
- rise_pulse  output  1  one-cycle strobe; high in the same cycle clk_out first goes high in each period.
- running  output  1  high while a period is in progress (including drain after enable drops).

Behaviour:
- Elaboration checks are fatal:
  - DIV < 2.
  - DUTY outside 1..99.
- Reset (rst_n=0, asynchronous):
  - clk_out=0, rise_pulse=0, running=0.
  - Period counter cnt=0, state IDLE.
- Counter cnt has width clog2(DIV). It counts 0..DIV-1 while running and wraps to 0.
- States:
  - IDLE: running=0, clk_out=0, cnt=0.
    - On a clk edge sampling enable=1: go to RUN with cnt=0, clk_out=1, rise_pulse=1, running=1.
    - First high level is visible the cycle after enable is sampled (1-cycle latency).
  - RUN: cnt increments each cycle; clk_out = (cnt_next < HIGH).
    - At cnt=DIV-1 with enable=1: wrap to 0, clk_out=1, rise_pulse=1.
    - At cnt=DIV-1 with enable=0: go to IDLE; clk_out stays 0.
- Graceful stop: dropping enable never truncates a period. The current high and low phases complete fully. No runt pulses.
- Re-raising enable before the period ends (drain) continues seamlessly with no gap or extra edge.
- Period is exactly DIV reference cycles; high time is exactly HIGH cycles.
- Example with REF_KHZ=400000, FREQ=50000:
  - DIV=8.
  - DUTY 25/60/75 gives HIGH 2/5/6.
- Asserting reset mid-period forces clk_out low immediately; no drain occurs.
- enable is treated as synchronous to clk; an external synchronizer is required for asynchronous sources.

Optional Feature:
- Macro: CLKGEN_PHASE_EN.
- Defined:
  - Adds parameter PHASE (default 0, range 0..DIV-1).
  - On leaving IDLE, the block waits PHASE reference cycles with clk_out=0 and running=1 before the first high cycle.
  - A PHASE-cycle delay is inserted only on a start from IDLE, never on wrap or seamless continuation.
  - enable dropping during the delay returns the block to IDLE with no pulse.
- Undefined: no PHASE parameter; behaviour is identical to PHASE=0.

Test Plan:
- Reset, then hold enable=0 for 50 cycles -> clk_out=0, running=0, rise_pulse=0 throughout.
- Defaults (DIV=4, HIGH=2), enable=1 -> first clk_out high one cycle after sampling; pattern 1100 repeating; rise_pulse on every 4th cycle, aligned with clk_out rise.
- FREQ=50000 with DUTY=25, 75 and 60 -> per period of 8 cycles, high counts 2, 6 and 5 respectively.
- FREQ=50000 DUTY=25, enable dropped at cnt=1 -> remaining high and low cycles complete; IDLE after cnt=7; running falls then, with no further rise_pulse.
- Enable dropped at cnt=3, re-raised at cnt=5 (DIV=8) -> next period starts exactly at wrap; no gap and no extra edge.
- rst_n asserted while clk_out=1 -> all outputs 0 immediately (asynchronous); after release with enable=1, restart with a full high phase.
